alu_exec_ctrl: RTL and testbench

Parametrised ALU control and execute sequencer for the datapath. It decodes the 3-bit ALU opcode class and function field into an operation code, then executes the operation on captured operands. Add, sub, logic, move, swap, compare and jump finish in one cycle; unsigned multiply and divide run iteratively over WIDTH cycles. Results are returned through a valid/ready handshake so the control unit can stall on multi-cycle ops.

---
 rtl/alu_exec_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_ctrl.sv
// ALU control decode and execute sequencer: single-cycle ops complete directly,
// unsigned multiply/divide iterate one bit per cycle; results leave through valid/ready.
module alu_exec_ctrl #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned FUNCT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         ALUop,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         operation,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   result_hi,
    output logic               zero,
    output logic               div_by_zero,
    output logic               busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    localparam logic [3:0] OpJump   = 4'b0000;
    localparam logic [3:0] OpAdd    = 4'b0001;
    localparam logic [3:0] OpSub    = 4'b0010;
    localparam logic [3:0] OpMult   = 4'b0011;
    localparam logic [3:0] OpDiv    = 4'b0100;
    localparam logic [3:0] OpMove   = 4'b0101;
    localparam logic [3:0] OpSwap   = 4'b0110;
    localparam logic [3:0] OpAnd    = 4'b0111;
    localparam logic [3:0] OpOr     = 4'b1000;
    localparam logic [3:0] OpBranch = 4'b1001;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic [3:0]        op_d;
    logic [WIDTH-1:0]  res_d, reshi_d;
    logic              zero_d, dbz_d;

    logic              accept, upper_nz, div0;
    logic [3:0]        dec_op;
    logic [WIDTH-1:0]  sc_res, sc_hi;
    logic [WIDTH:0]    mul_sum, div_sh;
    logic [WIDTH-1:0]  mul_hi, mul_lo, div_sub, div_rem, div_quo;
    logic              div_ge;

    assign in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StMul) | (state_q == StDiv);
    assign upper_nz  = |(funct >> 4);
    assign div0      = (dec_op == OpDiv) && (b == '0);

    always_comb begin
        dec_op = OpAdd;
        case (ALUop)
            3'b011: begin
                if (!upper_nz) begin
                    case (funct[3:0])
                        4'b0010: dec_op = OpSub;
                        4'b0100: dec_op = OpMult;
                        4'b0101: dec_op = OpDiv;
                        4'b0111: dec_op = OpMove;
                        4'b1000: dec_op = OpSwap;
                        default: dec_op = OpAdd;
                    endcase
                end
            end
            3'b010:  dec_op = funct[0] ? OpOr : OpAnd;
            3'b001:  dec_op = OpBranch;
            3'b000:  dec_op = OpJump;
            default: dec_op = OpAdd;
        endcase
    end

    always_comb begin
        sc_res = a + b;
        sc_hi  = '0;
        case (dec_op)
            OpSub, OpBranch: sc_res = a - b;
            OpMove:          sc_res = a;
            OpSwap: begin
                sc_res = b;
                sc_hi  = a;
            end
            OpAnd:           sc_res = a & b;
            OpOr:            sc_res = a | b;
            OpJump:          sc_res = '0;
            // Only reached with a zero divisor; real divides iterate.
            OpDiv: begin
                sc_res = '1;
                sc_hi  = a;
            end
            default:         sc_res = a + b;
        endcase
    end

    // Shift-add multiply on {hi,lo}; restoring divide with hi=remainder, lo=quotient.
    always_comb begin
        mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
        mul_hi  = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
        div_sh  = {hi_q, lo_q[WIDTH-1]};
        div_ge  = div_sh >= {1'b0, opnd_q};
        div_sub = div_sh[WIDTH-1:0] - opnd_q;
        div_rem = div_ge ? div_sub : div_sh[WIDTH-1:0];
        div_quo = {lo_q[WIDTH-2:0], div_ge};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        op_d    = operation;
        res_d   = result;
        reshi_d = result_hi;
        zero_d  = zero;
        dbz_d   = div_by_zero;
        unique case (state_q)
            StIdle, StDone: begin
                if (state_q == StDone && out_ready) state_d = StIdle;
                if (accept) begin
                    op_d  = dec_op;
                    cnt_d = CntLoad;
                    if (dec_op == OpMult) begin
                        state_d = StMul;
                        hi_d    = '0;
                        lo_d    = b;
                        opnd_d  = a;
                    end else if (dec_op == OpDiv && !div0) begin
                        state_d = StDiv;
                        hi_d    = '0;
                        lo_d    = a;
                        opnd_d  = b;
                    end else begin
                        state_d = StDone;
                        res_d   = sc_res;
                        reshi_d = sc_hi;
                        zero_d  = (sc_res == '0);
                        dbz_d   = div0;
                    end
                end
            end
            StMul: begin
                cnt_d = cnt_q - CntOne;
                hi_d  = mul_hi;
                lo_d  = mul_lo;
                if (cnt_q == CntOne) begin
                    state_d = StDone;
                    res_d   = mul_lo;
                    reshi_d = mul_hi;
                    zero_d  = (mul_lo == '0);
                    dbz_d   = 1'b0;
                end
            end
            StDiv: begin
                cnt_d = cnt_q - CntOne;
                hi_d  = div_rem;
                lo_d  = div_quo;
                if (cnt_q == CntOne) begin
                    state_d = StDone;
                    res_d   = div_quo;
                    reshi_d = div_rem;
                    zero_d  = (div_quo == '0);
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            operation   <= '0;
            result      <= '0;
            result_hi   <= '0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            opnd_q      <= opnd_d;
            operation   <= op_d;
            result      <= res_d;
            result_hi   <= reshi_d;
            zero        <= zero_d;
            div_by_zero <= dbz_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl: directed requests push expected results,
// a negedge monitor pops and compares every result the consumer takes.
module tb_alu_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  ALUop;
    logic [3:0]  funct;
    logic [15:0] a, b, result, result_hi;
    logic [3:0]  operation;
    logic        zero, div_by_zero, busy;

    typedef struct {
        string       name;
        logic [37:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    alu_exec_ctrl #(.WIDTH(16), .FUNCT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ALUop(ALUop),
        .funct(funct), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .operation(operation), .result(result), .result_hi(result_hi), .zero(zero),
        .div_by_zero(div_by_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: every result handed to the consumer must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result actual=%h required=none",
                         {operation, result, result_hi, zero, div_by_zero});
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, 64'({operation, result, result_hi, zero, div_by_zero}), 64'(e.v));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input string nm, input logic [2:0] op, input logic [3:0] fn,
                         input logic [15:0] xa, input logic [15:0] xb,
                         input logic [3:0] eop, input logic [15:0] eres,
                         input logic [15:0] ehi, input logic ez, input logic edz,
                         output int waited);
        int budget;
        exp_t e;
        ALUop    = op;
        funct    = fn;
        a        = xa;
        b        = xb;
        in_valid = 1'b1;
        waited   = 0;
        budget   = 60;
        @(negedge clk);
        while (!in_ready && budget > 0) begin
            waited++;
            budget--;
            @(negedge clk);
        end
        if (!in_ready) begin
            check({nm, "_accept_timeout"}, 64'(in_ready), 64'(1));
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            e.name = nm;
            e.v    = {eop, eres, ehi, ez, edz};
            exp_q.push_back(e);
            #1;
            in_valid = 1'b0;
            a        = 16'($urandom);
            b        = 16'($urandom);
            funct    = 4'($urandom);
            ALUop    = 3'($urandom);
        end
    endtask

    task automatic drain();
        int budget = 100;
        while (exp_q.size() != 0 && budget > 0) begin
            budget--;
            @(negedge clk);
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bit seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        ALUop = 3'b0; funct = 4'b0; a = 16'h0; b = 16'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", 64'({out_valid, busy, operation, result, result_hi, zero,
                                    div_by_zero}), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Single-cycle ops, back to back.
        issue("add_wrap", 3'b011, 4'b0000, 16'hFFFF, 16'h0001, 4'h1, 16'h0000, 16'h0, 1, 0, w);
        issue("swap", 3'b011, 4'b1000, 16'h1234, 16'hABCD, 4'h6, 16'hABCD, 16'h1234, 0, 0, w);
        check("swap_no_bubble", 64'(w), 64'(0));
        issue("sub", 3'b011, 4'b0010, 16'h0003, 16'h0005, 4'h2, 16'hFFFE, 16'h0, 0, 0, w);
        issue("and", 3'b010, 4'b0110, 16'hF0F0, 16'hFF00, 4'h7, 16'hF000, 16'h0, 0, 0, w);
        issue("move", 3'b011, 4'b0111, 16'h1234, 16'h5555, 4'h5, 16'h1234, 16'h0, 0, 0, w);
        issue("jump", 3'b000, 4'b0101, 16'h1111, 16'h2222, 4'h0, 16'h0000, 16'h0, 1, 0, w);
        issue("ldst100", 3'b100, 4'b0010, 16'h0010, 16'h0020, 4'h1, 16'h0030, 16'h0, 0, 0, w);
        issue("ldst111", 3'b111, 4'b1000, 16'h0001, 16'h0002, 4'h1, 16'h0003, 16'h0, 0, 0, w);
        issue("rtype_other", 3'b011, 4'b0011, 16'h0100, 16'h0011, 4'h1, 16'h0111, 16'h0,
              0, 0, w);
        drain();

        // Multiply latency: busy for 16 cycles, result on the 17th.
        issue("mult", 3'b011, 4'b0100, 16'h1234, 16'h0100, 4'h3, 16'h3400, 16'h0012, 0, 0, w);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("mult_busy_%0d", i), 64'({busy, in_ready, out_valid}), 64'(3'b100));
        end
        @(negedge clk);
        check("mult_done", 64'({busy, out_valid}), 64'(2'b01));
        @(posedge clk);
        #1;
        issue("div", 3'b011, 4'b0101, 16'h0064, 16'h0007, 4'h4, 16'h000E, 16'h0002, 0, 0, w);
        issue("div_zero", 3'b011, 4'b0101, 16'h0050, 16'h0000, 4'h4, 16'hFFFF, 16'h0050,
              0, 1, w);
        @(negedge clk);
        check("div_zero_next_cycle", 64'(out_valid), 64'(1));
        @(posedge clk);
        #1;
        issue("mult_max", 3'b011, 4'b0100, 16'hFFFF, 16'hFFFF, 4'h3, 16'h0001, 16'hFFFE,
              0, 0, w);
        issue("div_max", 3'b011, 4'b0101, 16'hFFFF, 16'h0010, 4'h4, 16'h0FFF, 16'h000F,
              0, 0, w);
        drain();

        // Backpressure on an OR result.
        out_ready = 1'b0;
        issue("or_held", 3'b010, 4'b0001, 16'h00F0, 16'h0F00, 4'h8, 16'h0FF0, 16'h0, 0, 0, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("or_stall_%0d", i), 64'({out_valid, in_ready, operation, result}),
                  64'({1'b1, 1'b0, 4'h8, 16'h0FF0}));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        issue("after_release", 3'b011, 4'b0000, 16'h0001, 16'h0001, 4'h1, 16'h0002, 16'h0,
              0, 0, w);
        check("release_accept_same_cycle", 64'(w), 64'(0));
        drain();

        // Asynchronous reset mid-cycle while a result is held.
        out_ready = 1'b0;
        issue("move_held", 3'b011, 4'b0111, 16'h5A5A, 16'h0000, 4'h5, 16'h5A5A, 16'h0, 0, 0, w);
        @(negedge clk);
        check("held_before_reset", 64'(out_valid), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", 64'({out_valid, busy, operation, result, result_hi, zero,
                                          div_by_zero}), 64'(0));
        exp_q.delete();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_release", 64'({in_ready, out_valid}), 64'(2'b10));

        // Reset at iteration 8 of a multiply discards it.
        issue("mult_killed", 3'b011, 4'b0100, 16'h1234, 16'h0100, 4'h3, 16'h3400, 16'h0012,
              0, 0, w);
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        check("killed_mult_silent", 64'(seen), 64'(0));
        @(posedge clk);
        #1;
        issue("branch_eq", 3'b001, 4'b0000, 16'h0005, 16'h0005, 4'h9, 16'h0000, 16'h0, 1, 0, w);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
